// File: rtl/debug_sweep_pkg.sv
// Shared encodings for the debug sweeper: command ops, FSM states, checksum address.
package debug_sweep_pkg;

  typedef enum logic [1:0] {
    OP_STEP      = 2'd0,
    OP_DUMP      = 2'd1,
    OP_STEP_DUMP = 2'd2,
    OP_RUN       = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STEP_HI = 3'd1,
    S_STEP_LO = 3'd2,
    S_SETTLE  = 3'd3,
    S_SEND    = 3'd4
  } state_e;

  localparam logic [6:0] CHECKSUM_ADDR = 7'h7F;

endpackage

// File: rtl/debug_sweeper_step_pulse_gen.sv
// One debug_step high/low pulse pair, each phase STEP_PULSE clocks wide.
// The step output is registered so the core's step clock never glitches.
module step_pulse_gen #(
  parameter int STEP_PULSE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic step_o,
  output logic hi_done_o,
  output logic done_o
);

  localparam int CW = $clog2(STEP_PULSE + 1);
  localparam logic [CW-1:0] RELOAD = CW'(STEP_PULSE - 1);

  logic          busy_q, busy_d;
  logic          hi_q, hi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc;

  assign tc        = (cnt_q == '0);
  assign hi_done_o = busy_q & hi_q & tc;
  assign done_o    = busy_q & ~hi_q & tc;
  assign step_o    = hi_q;

  // Down-counter reloads at the start of each phase; terminal count ends the phase.
  always_comb begin
    busy_d = busy_q;
    hi_d   = hi_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      busy_d = 1'b1;
      hi_d   = 1'b1;
      cnt_d  = RELOAD;
    end else if (busy_q) begin
      if (tc) begin
        cnt_d = RELOAD;
        if (hi_q) hi_d = 1'b0;
        else      busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Phase and counter registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= 1'b0;
      hi_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      hi_q   <= hi_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/debug_sweeper.sv
// Debug-port initiator: single-step, free-run, or sweep a debug address range
// onto a valid/ready dump stream.
// Optional: DEBUG_SWEEP_CHECKSUM_EN appends an XOR checksum word at address 7'h7F.
//
// state     | meaning
// IDLE      | waiting for a command, cmd_ready high
// STEP_HI   | debug_step high for STEP_PULSE clocks
// STEP_LO   | debug_step low for STEP_PULSE clocks
// SETTLE    | debug_addr stable, debug_data captured at the end
// SEND      | dump word presented, waiting for out_ready
module debug_sweeper
  import debug_sweep_pkg::*;
#(
  parameter int DUMP_FIRST = 0,
  parameter int DUMP_LAST  = 63,
  parameter int STEP_PULSE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  output logic        debug_en,
  output logic        debug_step,
  output logic [6:0]  debug_addr,
  input  logic [31:0] debug_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [6:0]  out_addr,
  output logic        out_last
);

  localparam logic [6:0] ADDR_FIRST = 7'(DUMP_FIRST);
  localparam logic [6:0] ADDR_LAST  = 7'(DUMP_LAST);

  state_e      state_q, state_d;
  logic        dump_after_q, dump_after_d;
  logic        en_q, en_d;
  logic [6:0]  addr_q, addr_d;
  logic        ov_q, ov_d;
  logic [31:0] od_q, od_d;
  logic [6:0]  oa_q, oa_d;
  logic        ol_q, ol_d;
  logic        step_start;
  logic        hi_done, step_done;
`ifdef DEBUG_SWEEP_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  step_pulse_gen #(.STEP_PULSE(STEP_PULSE)) u_step (
    .clk       (clk),
    .rst       (rst),
    .start_i   (step_start),
    .step_o    (debug_step),
    .hi_done_o (hi_done),
    .done_o    (step_done)
  );

  assign cmd_ready  = (state_q == S_IDLE);
  assign debug_en   = en_q;
  assign debug_addr = addr_q;
  assign out_valid  = ov_q;
  assign out_data   = od_q;
  assign out_addr   = oa_q;
  assign out_last   = ol_q;

  // Next-state, command acceptance and dump-word capture.
  always_comb begin
    state_d      = state_q;
    dump_after_d = dump_after_q;
    en_d         = en_q;
    addr_d       = addr_q;
    ov_d         = ov_q;
    od_d         = od_q;
    oa_d         = oa_q;
    ol_d         = ol_q;
    step_start   = 1'b0;
`ifdef DEBUG_SWEEP_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_STEP, OP_STEP_DUMP: begin
              state_d      = S_STEP_HI;
              en_d         = 1'b1;
              step_start   = 1'b1;
              dump_after_d = (op_e'(cmd_op) == OP_STEP_DUMP);
            end
            OP_DUMP: begin
              state_d = S_SETTLE;
              en_d    = 1'b1;
              addr_d  = ADDR_FIRST;
`ifdef DEBUG_SWEEP_CHECKSUM_EN
              csum_d  = '0;
`endif
            end
            default: en_d = 1'b0;
          endcase
        end
      end
      S_STEP_HI: begin
        if (hi_done) state_d = S_STEP_LO;
      end
      S_STEP_LO: begin
        if (step_done) begin
          if (dump_after_q) begin
            state_d = S_SETTLE;
            addr_d  = ADDR_FIRST;
`ifdef DEBUG_SWEEP_CHECKSUM_EN
            csum_d  = '0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_SETTLE: begin
        od_d    = debug_data;
        oa_d    = addr_q;
        ov_d    = 1'b1;
        state_d = S_SEND;
`ifdef DEBUG_SWEEP_CHECKSUM_EN
        ol_d    = 1'b0;
        csum_d  = csum_q ^ debug_data;
`else
        ol_d    = (addr_q == ADDR_LAST);
`endif
      end
      S_SEND: begin
        if (out_ready) begin
          if (ol_q) begin
            ov_d    = 1'b0;
            state_d = S_IDLE;
`ifdef DEBUG_SWEEP_CHECKSUM_EN
          end else if (oa_q == ADDR_LAST) begin
            // Checksum word follows directly; out_valid stays high.
            od_d = csum_q;
            oa_d = CHECKSUM_ADDR;
            ol_d = 1'b1;
`endif
          end else begin
            ov_d    = 1'b0;
            addr_d  = addr_q + 7'd1;
            state_d = S_SETTLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      dump_after_q <= 1'b0;
      en_q         <= 1'b1;
      addr_q       <= ADDR_FIRST;
      ov_q         <= 1'b0;
      od_q         <= '0;
      oa_q         <= '0;
      ol_q         <= 1'b0;
`ifdef DEBUG_SWEEP_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dump_after_q <= dump_after_d;
      en_q         <= en_d;
      addr_q       <= addr_d;
      ov_q         <= ov_d;
      od_q         <= od_d;
      oa_q         <= oa_d;
      ol_q         <= ol_d;
`ifdef DEBUG_SWEEP_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_debug_sweeper.sv
// Scoreboard bench for debug_sweeper: command stimulus pushes the expected dump
// words, an independent monitor pops them on each stream handshake.
module tb_debug_sweeper;
  import debug_sweep_pkg::*;

  localparam int FIRST = 0;
  localparam int LAST  = 63;
  localparam int P     = 4;
`ifdef DEBUG_SWEEP_CHECKSUM_EN
  localparam int DUMP_CYCLES = 129;
`else
  localparam int DUMP_CYCLES = 128;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic        debug_en, debug_step;
  logic [6:0]  debug_addr;
  logic [31:0] debug_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [6:0]  out_addr;
  logic        out_last;

  debug_sweeper #(.DUMP_FIRST(FIRST), .DUMP_LAST(LAST), .STEP_PULSE(P)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .debug_en(debug_en), .debug_step(debug_step), .debug_addr(debug_addr),
    .debug_data(debug_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
  );

  // Core model: combinational read data derived from the address.
  assign debug_data = 32'hA5A5_0000 | {25'd0, debug_addr};

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [6:0]  a;
    logic        l;
  } word_t;

  word_t exp_q[$];
  word_t mw;
  int    errors = 0;
  int    checks = 0;
  int    ready_mode = 0;
  int    stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: one full sweep of the range, plus checksum word when enabled.
  function automatic void push_dump();
    logic [31:0] x;
    word_t       w;
    x = '0;
    for (int a = FIRST; a <= LAST; a++) begin
      w.d = 32'hA5A5_0000 | 32'(a);
      w.a = 7'(a);
`ifdef DEBUG_SWEEP_CHECKSUM_EN
      w.l = 1'b0;
`else
      w.l = (a == LAST);
`endif
      x = x ^ w.d;
      exp_q.push_back(w);
    end
`ifdef DEBUG_SWEEP_CHECKSUM_EN
    w.d = x;
    w.a = 7'h7F;
    w.l = 1'b1;
    exp_q.push_back(w);
`endif
  endfunction

  // Monitor: every accepted word is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      chk("step_during_send", {31'd0, debug_step}, 32'd0);
      if (out_addr != 7'h7F) chk("addr_held", {25'd0, debug_addr}, {25'd0, out_addr});
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got addr %h expected none", out_addr);
        end else begin
          mw = exp_q.pop_front();
          chk("word_data", out_data, mw.d);
          chk("word_addr", {25'd0, out_addr}, {25'd0, mw.a});
          chk("word_last", {31'd0, out_last}, {31'd0, mw.l});
        end
      end
    end
  end

  // Consumer back-pressure: always ready, random, or a 5-cycle stall on word 3.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (out_valid && out_addr == 7'd3 && stall_cnt < 5) begin
          out_ready = 1'b0;
          stall_cnt++;
          chk("stall_data", out_data, 32'hA5A5_0003);
          chk("stall_out_addr", {25'd0, out_addr}, 32'd3);
          chk("stall_dbg_addr", {25'd0, debug_addr}, 32'd3);
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  task automatic issue(input logic [1:0] op);
    int n;
    n = 0;
    while (!cmd_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) chk("issue_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (op == OP_DUMP || op == OP_STEP_DUMP) push_dump();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!cmd_ready && n < 3000);
    if (n >= 3000) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_en"},    {31'd0, debug_en},   32'd1);
    chk({tag, "_step"},  {31'd0, debug_step}, 32'd0);
    chk({tag, "_daddr"}, {25'd0, debug_addr}, 32'(FIRST));
    chk({tag, "_valid"}, {31'd0, out_valid},  32'd0);
    chk({tag, "_data"},  out_data,            32'd0);
    chk({tag, "_oaddr"}, {25'd0, out_addr},   32'd0);
    chk({tag, "_last"},  {31'd0, out_last},   32'd0);
    chk({tag, "_ready"}, {31'd0, cmd_ready},  32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] op;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Full dump with out_ready held high.
    issue(OP_DUMP);
    chk("dump_valid_at_accept", {31'd0, out_valid}, 32'd0);
    wait_idle(n);
    chk("dump_cycles", n, DUMP_CYCLES);
    @(posedge clk); #1;
    chk("dump_queue_empty", exp_q.size(), 32'd0);

    // Back-pressure on word 3.
    ready_mode = 2;
    stall_cnt  = 0;
    issue(OP_DUMP);
    wait_idle(n);
    ready_mode = 0;
    @(posedge clk); #1;
    chk("stall_cycles", stall_cnt, 32'd5);
    chk("stall_queue_empty", exp_q.size(), 32'd0);

    // STEP: 4 high, 4 low, busy for 8 cycles.
    issue(OP_STEP);
    chk("step_en", {31'd0, debug_en}, 32'd1);
    for (int j = 0; j < 10; j++) begin
      chk("step_pulse", {31'd0, debug_step}, {31'd0, (j < P)});
      chk("step_ready", {31'd0, cmd_ready}, {31'd0, (j >= 2 * P)});
      @(posedge clk); #1;
    end

    // RUN then DUMP.
    issue(OP_RUN);
    chk("run_en", {31'd0, debug_en}, 32'd0);
    chk("run_ready", {31'd0, cmd_ready}, 32'd1);
    issue(OP_DUMP);
    chk("dump_after_run_en", {31'd0, debug_en}, 32'd1);
    wait_idle(n);
    @(posedge clk); #1;
    chk("run_dump_queue_empty", exp_q.size(), 32'd0);

    // Reset in the middle of a dump, at word 10.
    issue(OP_DUMP);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_addr == 7'd10) && n < 500);
    if (n >= 500) chk("word10_timeout", 32'd0, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("midreset");
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    issue(OP_DUMP);
    wait_idle(n);
    chk("restart_cycles", n, DUMP_CYCLES);
    @(posedge clk); #1;
    chk("restart_queue_empty", exp_q.size(), 32'd0);

    // Random command sequence with random back-pressure.
    ready_mode = 1;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      issue(op);
      chk("rand_en", {31'd0, debug_en}, {31'd0, (op != OP_RUN)});
      wait_idle(n);
    end
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rand_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
